// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter sharing one 32-point FFT pipeline between two sample sources.
// Each granted frame is tagged so the FFT result stream can be routed back to its channel.
module fft_frame_arbiter #(
    parameter int DATA_W    = 11,
    parameter int OUT_W     = 17,
    parameter int FRAME_LEN = 32,
    parameter int MAX_OUT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ch0_valid,
    input  logic [DATA_W-1:0] ch0_data,
    output logic              ch0_ready,
    input  logic              ch1_valid,
    input  logic [DATA_W-1:0] ch1_data,
    output logic              ch1_ready,
    output logic              fft_valid_i,
    output logic [DATA_W-1:0] fft_x_r,
    input  logic              fft_finish,
    input  logic [OUT_W-1:0]  fft_answer,
    output logic              res_valid,
    output logic [OUT_W-1:0]  res_data,
    output logic              res_chan,
    output logic              res_last,
    output logic              busy,
    output logic              err
);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int AW    = $clog2(MAX_OUT);
    localparam int PTR_W = AW + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [MAX_OUT-1:0] tag_mem_q;

    logic               ch0_ready_q, ch1_ready_q;
    logic               fft_valid_q;
    logic [DATA_W-1:0]  fft_x_q;
    logic               res_valid_q, res_chan_q, res_last_q;
    logic [OUT_W-1:0]   res_data_q;
    logic               busy_q, err_q;

    logic               fifo_empty_s, fifo_full_s;
    logic               sel_valid_s, accept_s, push_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               res_beat_s, pop_s, head_tag_s;

    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign sel_valid_s  = gnt_q ? ch1_valid : ch0_valid;
    assign sel_data_s   = gnt_q ? ch1_data  : ch0_data;
    assign accept_s     = (state_q == STREAM) && sel_valid_s;
    // A finish beat with no tag outstanding is dropped and only flags err.
    assign res_beat_s   = fft_finish && !fifo_empty_s;
    assign pop_s        = res_beat_s && (out_cnt_q == LAST_BEAT);
    assign head_tag_s   = tag_mem_q[rd_ptr_q[AW-1:0]];

    // Arbitration FSM, beat counters and tag FIFO pointer updates.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        in_cnt_d   = in_cnt_q;
        push_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((ch0_valid || ch1_valid) && !fifo_full_s) begin
                    if (ch0_valid && ch1_valid) begin
                        gnt_d = ~last_gnt_q;
                    end else begin
                        gnt_d = ch1_valid;
                    end
                    last_gnt_d = gnt_d;
                    push_s     = 1'b1;
                    in_cnt_d   = CNT_ZERO;
                    state_d    = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (accept_s && (in_cnt_q == LAST_BEAT)) begin
                    in_cnt_d = CNT_ZERO;
                    state_d  = IDLE;
                end else if (accept_s) begin
                    in_cnt_d = in_cnt_q + CNT_ONE;
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (res_beat_s && (out_cnt_q == LAST_BEAT)) begin
            out_cnt_d = CNT_ZERO;
        end else if (res_beat_s) begin
            out_cnt_d = out_cnt_q + CNT_ONE;
        end else begin
            out_cnt_d = out_cnt_q;
        end

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_s};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
    end

    // State, tag storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            in_cnt_q    <= CNT_ZERO;
            out_cnt_q   <= CNT_ZERO;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            tag_mem_q   <= {MAX_OUT{1'b0}};
            ch0_ready_q <= 1'b0;
            ch1_ready_q <= 1'b0;
            fft_valid_q <= 1'b0;
            fft_x_q     <= {DATA_W{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {OUT_W{1'b0}};
            res_chan_q  <= 1'b0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push_s) begin
                tag_mem_q[wr_ptr_q[AW-1:0]] <= gnt_d;
            end
            ch0_ready_q <= (state_d == STREAM) && !gnt_d;
            ch1_ready_q <= (state_d == STREAM) && gnt_d;
            fft_valid_q <= accept_s;
            if (accept_s) begin
                fft_x_q <= sel_data_s;
            end
            res_valid_q <= res_beat_s;
            if (res_beat_s) begin
                res_data_q <= fft_answer;
                res_chan_q <= head_tag_s;
                res_last_q <= (out_cnt_q == LAST_BEAT);
            end
            busy_q <= (state_d == STREAM) || (wr_ptr_d != rd_ptr_d);
            if (fft_finish && fifo_empty_s) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ch0_ready   = ch0_ready_q;
    assign ch1_ready   = ch1_ready_q;
    assign fft_valid_i = fft_valid_q;
    assign fft_x_r     = fft_x_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_chan    = res_chan_q;
    assign res_last    = res_last_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed + randomized bench for fft_frame_arbiter against a queue-based frame/tag reference model.
module tb_fft_frame_arbiter;
    localparam int DATA_W    = 11;
    localparam int OUT_W     = 17;
    localparam int FRAME_LEN = 32;
    localparam int MAX_OUT   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ch0_valid, ch1_valid;
    logic [DATA_W-1:0] ch0_data, ch1_data;
    logic              ch0_ready, ch1_ready;
    logic              fft_valid_i;
    logic [DATA_W-1:0] fft_x_r;
    logic              fft_finish;
    logic [OUT_W-1:0]  fft_answer;
    logic              res_valid, res_chan, res_last, busy, err;
    logic [OUT_W-1:0]  res_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fft_frame_arbiter #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .FRAME_LEN(FRAME_LEN), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
        .fft_valid_i(fft_valid_i), .fft_x_r(fft_x_r),
        .fft_finish(fft_finish), .fft_answer(fft_answer),
        .res_valid(res_valid), .res_data(res_data), .res_chan(res_chan),
        .res_last(res_last), .busy(busy), .err(err)
    );

    // Reference model: which channel owns the input stream, and the queue of frames in flight.
    int   m_chan;
    int   m_cnt;
    int   m_last;
    int   m_beats;
    bit   m_tags[$];
    logic e_r0, e_r1, e_fv, e_rv, e_rc, e_rl, e_busy, e_err;
    logic [DATA_W-1:0] e_fx;
    logic [OUT_W-1:0]  e_rd;

    // Stimulus bookkeeping.
    int  seq0, seq1, fv_total, pend, guard;
    bit  rand_data, auto_fft;
    bit  prev_r0, prev_r1;
    int  obs_grants[$];
    int  obs_last_chans[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_chan = -1; m_cnt = 0; m_last = 1; m_beats = 0;
        m_tags.delete();
        e_r0 = 1'b0; e_r1 = 1'b0; e_fv = 1'b0; e_fx = '0;
        e_rv = 1'b0; e_rd = '0; e_rc = 1'b0; e_rl = 1'b0;
        e_busy = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_step();
        bit full, acc;
        int g;
        if (rst) begin
            model_reset();
            return;
        end
        full = (m_tags.size() == MAX_OUT);
        acc  = (m_chan == 0) ? ch0_valid : ((m_chan == 1) ? ch1_valid : 1'b0);
        e_fv = acc;
        if (acc) e_fx = (m_chan == 0) ? ch0_data : ch1_data;
        e_rv = 1'b0;
        if (fft_finish) begin
            if (m_tags.size() == 0) begin
                e_err = 1'b1;
            end else begin
                e_rv = 1'b1;
                e_rd = fft_answer;
                e_rc = m_tags[0];
                e_rl = (m_beats == FRAME_LEN - 1);
                m_beats = (m_beats + 1) % FRAME_LEN;
                if (e_rl) void'(m_tags.pop_front());
            end
        end
        if (m_chan < 0) begin
            if ((ch0_valid || ch1_valid) && !full) begin
                g = (ch0_valid && ch1_valid) ? (1 - m_last) : (ch1_valid ? 1 : 0);
                m_last = g;
                m_tags.push_back(g[0]);
                m_chan = g;
                m_cnt  = 0;
            end
        end else if (acc) begin
            m_cnt++;
            if (m_cnt == FRAME_LEN) m_chan = -1;
        end
        e_r0   = (m_chan == 0);
        e_r1   = (m_chan == 1);
        e_busy = (m_chan >= 0) || (m_tags.size() > 0);
    endtask

    task automatic cycle();
        bit acc0, acc1;
        if (auto_fft) begin
            fft_finish = (pend > 0) && ($urandom_range(0, 3) != 0);
            fft_answer = OUT_W'($urandom);
        end
        if (rand_data) begin
            ch0_data = DATA_W'($urandom);
            ch1_data = DATA_W'($urandom);
        end else begin
            ch0_data = DATA_W'(seq0);
            ch1_data = DATA_W'(seq1 + 100);
        end
        acc0 = ch0_valid && ch0_ready;
        acc1 = ch1_valid && ch1_ready;
        if (fft_finish && pend > 0) pend--;
        model_step();
        @(posedge clk);
        #1;
        seq0 += int'(acc0);
        seq1 += int'(acc1);
        if (fft_valid_i) begin
            fv_total++;
            if (fv_total % FRAME_LEN == 0) pend += FRAME_LEN;
        end
        if (res_valid && res_last) obs_last_chans.push_back(int'(res_chan));
        if (ch0_ready && !prev_r0) obs_grants.push_back(0);
        if (ch1_ready && !prev_r1) obs_grants.push_back(1);
        prev_r0 = ch0_ready;
        prev_r1 = ch1_ready;
        chk("ch0_ready",   32'(ch0_ready),   32'(e_r0));
        chk("ch1_ready",   32'(ch1_ready),   32'(e_r1));
        chk("fft_valid_i", 32'(fft_valid_i), 32'(e_fv));
        chk("fft_x_r",     32'(fft_x_r),     32'(e_fx));
        chk("res_valid",   32'(res_valid),   32'(e_rv));
        chk("res_data",    32'(res_data),    32'(e_rd));
        chk("res_chan",    32'(res_chan),    32'(e_rc));
        chk("res_last",    32'(res_last),    32'(e_rl));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("err",         32'(err),         32'(e_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        seq0 = 0; seq1 = 0; pend = 0; fv_total = 0;
        obs_grants.delete();
        obs_last_chans.delete();
    endtask

    task automatic fin_burst(input int n);
        fft_finish = 1'b1;
        repeat (n) begin
            fft_answer = OUT_W'($urandom);
            cycle();
        end
        fft_finish = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_data = '0; ch1_data = '0;
        fft_finish = 1'b0; fft_answer = '0; rand_data = 1'b0; auto_fft = 1'b0;
        prev_r0 = 1'b0; prev_r1 = 1'b0;
        seq0 = 0; seq1 = 0; pend = 0; fv_total = 0;
        model_reset();
        do_reset();
        cycle();

        // Single ch0 frame carrying samples 0..31, then its 32 result beats.
        ch0_valid = 1'b1;
        guard = 0;
        while (seq0 < FRAME_LEN && guard < 200) begin cycle(); guard++; end
        chk("p1_timeout", 32'(guard < 200), 32'd1);
        ch0_valid = 1'b0;
        cycle(); cycle();
        chk("p1_fft_beats", 32'(fv_total), 32'(FRAME_LEN));
        chk("p1_grants", 32'(obs_grants.size()), 32'd1);
        fin_burst(FRAME_LEN);
        cycle();
        chk("p1_res_frames", 32'(obs_last_chans.size()), 32'd1);
        if (obs_last_chans.size() > 0) chk("p1_res_chan", 32'(obs_last_chans[0]), 32'd0);
        chk("p1_busy", 32'(busy), 32'd0);

        // Contention and outstanding limit: four frames fill the tag FIFO, the fifth waits for a pop.
        do_reset();
        rand_data = 1'b1;
        ch0_valid = 1'b1; ch1_valid = 1'b1;
        guard = 0;
        while (obs_grants.size() < MAX_OUT && guard < 400) begin cycle(); guard++; end
        guard = 0;
        while ((ch0_ready || ch1_ready) && guard < 100) begin cycle(); guard++; end
        repeat (20) begin
            cycle();
            chk("p2_stalled_ready", 32'(ch0_ready | ch1_ready), 32'd0);
        end
        chk("p2_grants_before_pop", 32'(obs_grants.size()), 32'(MAX_OUT));
        fin_burst(FRAME_LEN);
        guard = 0;
        while (obs_grants.size() < MAX_OUT + 1 && guard < 50) begin cycle(); guard++; end
        chk("p2_fifth_grant", 32'(obs_grants.size()), 32'(MAX_OUT + 1));
        guard = 0;
        while ((ch0_ready || ch1_ready) && guard < 100) begin cycle(); guard++; end
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        repeat (MAX_OUT) begin
            cycle();
            fin_burst(FRAME_LEN);
        end
        cycle();
        chk("p2_grant_count", 32'(obs_grants.size()), 32'd5);
        chk("p2_res_frames", 32'(obs_last_chans.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < obs_grants.size())     chk("p2_grant_seq", 32'(obs_grants[i]), 32'(i % 2));
            if (i < obs_last_chans.size()) chk("p2_res_chan_seq", 32'(obs_last_chans[i]), 32'(i % 2));
        end
        chk("p2_busy", 32'(busy), 32'd0);

        // ch1 frame with a 3-cycle gap after 5 samples; ch0 must never be accepted meanwhile.
        do_reset();
        rand_data = 1'b0;
        ch1_valid = 1'b1;
        guard = 0;
        while (!ch1_ready && guard < 10) begin cycle(); guard++; end
        ch0_valid = 1'b1;
        guard = 0;
        while (seq1 < 5 && guard < 20) begin cycle(); guard++; chk("p3_ch0_ready", 32'(ch0_ready), 32'd0); end
        ch1_valid = 1'b0;
        repeat (3) begin cycle(); chk("p3_ch0_ready_gap", 32'(ch0_ready), 32'd0); end
        ch1_valid = 1'b1;
        guard = 0;
        while (seq1 < FRAME_LEN && guard < 60) begin
            chk("p3_ch0_ready_tail", 32'(ch0_ready), 32'd0);
            cycle(); guard++;
        end
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        cycle(); cycle();
        chk("p3_fft_beats", 32'(fv_total), 32'(FRAME_LEN));
        chk("p3_ch0_accepted", 32'(seq0), 32'd0);
        if (obs_grants.size() > 0) chk("p3_grant", 32'(obs_grants[0]), 32'd1);
        fin_burst(FRAME_LEN);
        cycle();
        if (obs_last_chans.size() > 0) chk("p3_res_chan", 32'(obs_last_chans[0]), 32'd1);
        chk("p3_res_frames", 32'(obs_last_chans.size()), 32'd1);

        // Randomized traffic with an FFT stand-in returning one result burst per completed frame.
        do_reset();
        rand_data = 1'b1;
        auto_fft  = 1'b1;
        repeat (1500) begin
            ch0_valid = ($urandom_range(0, 9) < 6);
            ch1_valid = ($urandom_range(0, 9) < 5);
            cycle();
        end
        guard = 0;
        while ((busy || pend > 0) && guard < 3000) begin
            ch0_valid = ch0_ready;
            ch1_valid = ch1_ready;
            cycle();
            guard++;
        end
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        auto_fft = 1'b0; fft_finish = 1'b0;
        cycle();
        chk("p4_drained", 32'(busy), 32'd0);
        chk("p4_no_err", 32'(err), 32'd0);

        // Spurious finish with nothing in flight.
        do_reset();
        fft_finish = 1'b1;
        fft_answer = OUT_W'(17'h1abcd);
        cycle();
        fft_finish = 1'b0;
        chk("p5_res_valid", 32'(res_valid), 32'd0);
        chk("p5_err", 32'(err), 32'd1);
        cycle();
        chk("p5_err_sticky", 32'(err), 32'd1);

        // Reset mid-frame: outputs and err clear, and ch0 wins the first contended grant.
        rand_data = 1'b0;
        seq0 = 0;
        ch0_valid = 1'b1;
        guard = 0;
        while (seq0 < 10 && guard < 30) begin cycle(); guard++; end
        chk("p6_in_stream", 32'(ch0_ready), 32'd1);
        rst = 1'b1;
        ch1_valid = 1'b1;
        cycle();
        rst = 1'b0;
        chk("p6_rst_err", 32'(err), 32'd0);
        chk("p6_rst_busy", 32'(busy), 32'd0);
        chk("p6_rst_ready", 32'(ch0_ready | ch1_ready), 32'd0);
        chk("p6_rst_fft_valid", 32'(fft_valid_i), 32'd0);
        obs_grants.delete();
        guard = 0;
        while (obs_grants.size() == 0 && guard < 10) begin cycle(); guard++; end
        chk("p6_grant_seen", 32'(obs_grants.size()), 32'd1);
        if (obs_grants.size() > 0) chk("p6_first_grant", 32'(obs_grants[0]), 32'd0);
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares the single 32-point FFT pipeline between two sample sources.
- Grants whole 32-sample frames round-robin and streams the granted frame into the FFT input (valid_i / x_r).
- Tags every frame in flight, then routes the FFT result stream (finish / answer) back with the channel ID of the frame that produced it.
- Sits between the acquisition front-ends and the FFT top.

Parameters:
- DATA_W, 11, input sample width (signed, 5 integer + 6 fractional bits).
- OUT_W, 17, FFT result width (signed).
- FRAME_LEN, 32, samples per frame and results per frame.
- MAX_OUT, 4, maximum frames in flight inside the FFT; depth of the tag FIFO (power of 2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ch0_valid  in  1  channel 0 sample valid.
- ch0_data  in  DATA_W  channel 0 sample.
- ch0_ready  out  1  channel 0 sample accepted this cycle.
- ch1_valid  in  1  channel 1 sample valid.
- ch1_data  in  DATA_W  channel 1 sample.
- ch1_ready  out  1  channel 1 sample accepted this cycle.
- fft_valid_i  out  1  to FFT valid_i.
- fft_x_r  out  DATA_W  to FFT x_r.
- fft_finish  in  1  from FFT finish; high for each of the FRAME_LEN result beats of a frame.
- fft_answer  in  OUT_W  from FFT answer.
- res_valid  out  1  result beat valid.
- res_data  out  OUT_W  result value.
- res_chan  out  1  channel that owns the result.
- res_last  out  1  final (FRAME_LEN-th) beat of a result frame.
- busy  out  1  STREAM state active or tag FIFO non-empty.
- err  out  1  sticky: fft_finish seen while tag FIFO empty.

Behaviour:
- Reset, synchronous and active-high:
  - All outputs 0; state = IDLE.
  - Round-robin pointer last_gnt = 1, so channel 0 wins first.
  - Beat counters = 0; tag FIFO empty; err = 0.
- FSM states: IDLE, STREAM.
- IDLE:
  - Grant when any chN_valid = 1 and the tag FIFO is not full.
  - If both channels are valid, grant the channel != last_gnt. If only one is valid, grant that channel.
  - On grant: latch gnt, set last_gnt = gnt, push gnt into the tag FIFO, in_cnt = 0, go to STREAM.
  - chN_ready = 0 in IDLE (one-cycle arbitration bubble).
  - Tag FIFO full: no grant, stay in IDLE, both ready = 0.
- STREAM:
  - ch[gnt]_ready = 1; the other channel's ready = 0.
  - Registered pass-through: fft_valid_i <= ch[gnt]_valid; fft_x_r <= ch[gnt]_data, loaded only when valid, otherwise held.
  - Input-to-FFT latency is 1 cycle.
  - A gap (ch[gnt]_valid = 0) is forwarded as fft_valid_i = 0. The FFT stages advance only on valid_i, so gaps are legal. in_cnt does not advance on a gap.
  - On the accepted beat with in_cnt == FRAME_LEN-1, go to IDLE.
  - The non-granted channel is never accepted, even if valid.
- fft_valid_i is 0 whenever no sample was accepted in the previous cycle.
- Result path:
  - out_cnt counts fft_finish beats modulo FRAME_LEN.
  - Each finish beat with the FIFO non-empty is a result beat (1-cycle registered): res_valid = 1, res_data = fft_answer, res_chan = FIFO head, res_last = (out_cnt == FRAME_LEN-1).
  - Pop the tag FIFO on the res_last beat.
  - res_* hold their last values when res_valid = 0.
- Spurious finish: fft_finish = 1 with the FIFO empty drops the beat (res_valid = 0), sets err, and leaves out_cnt unchanged.
- Push and pop in the same cycle: occupancy is unchanged and both take effect. If the FIFO is full at the start of that cycle, no grant occurs that cycle, because the full check uses current occupancy.
- Wrap-around: FIFO pointers are log2(MAX_OUT)+1 bits; full = MSBs differ and the rest equal. Counters wrap at FRAME_LEN.
- Reset mid-frame: the in-flight frame and its tags are discarded. Downstream results still emerging from the FFT then hit an empty FIFO and set err. Issuing reset to the FFT at the same time is mandatory.
- No backpressure on res_*; the consumer must accept every beat.

Test Plan:
- Single frame, ch0 only:
  - ch0 presents samples 0..31 contiguously → ch0_ready rises 1 cycle after ch0_valid; fft_valid_i high 32 cycles with fft_x_r = 0..31; back to IDLE.
  - 32 finish beats → res_chan = 0 on all 32 beats, res_last only on beat 32, busy = 0 afterwards.
- Contention:
  - ch0 and ch1 valid continuously → grants alternate ch0, ch1, ch0, ch1, each 32 beats, separated by exactly 1 idle cycle.
  - res_chan sequence per frame is 0, 1, 0, 1.
- Gaps:
  - ch1 frame with valid low on beats 5–7 → fft_valid_i low for those 3 cycles and frame length still 32 accepted samples.
  - The non-granted ch0 sees ready = 0 throughout.
- Outstanding limit:
  - Feed 5 back-to-back frames with fft_finish held 0 → 4 frames are streamed, the 5th is not granted and ready stays 0.
  - After the first 32-beat result burst (pop) → the 5th frame is granted.
- Spurious finish and reset:
  - Pulse fft_finish after reset with no frame sent → res_valid stays 0 and err = 1.
  - Assert rst mid-STREAM at beat 10 → next cycle all outputs 0, err = 0, IDLE, and ch0 is granted first.
